// File: rtl/controlador_displays.sv
// rtl/controlador_displays.sv - time-multiplexed scan controller for a common-anode 7-segment bank.
// Optional leading-zero blanking is enabled by defining SUPRESION_CEROS_EN.
module controlador_displays #(
  parameter int N_DIGITOS    = 4,
  parameter int DIV_REFRESCO = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*N_DIGITOS-1:0] digitos,
  input  logic [N_DIGITOS-1:0]   punto,
  input  logic                   habilitar,
  output logic [3:0]             bcd,
  output logic [N_DIGITOS-1:0]   anodos,
  output logic                   dp,
  output logic                   fin_barrido
);

  localparam int ANCHO_DIV = $clog2(DIV_REFRESCO);
  localparam int ANCHO_IDX = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam logic [ANCHO_DIV-1:0] PRESC_MAX = ANCHO_DIV'(DIV_REFRESCO - 1);
  localparam logic [ANCHO_IDX-1:0] IDX_MAX   = ANCHO_IDX'(N_DIGITOS - 1);

  logic [ANCHO_DIV-1:0]   prescaler;
  logic [ANCHO_IDX-1:0]   index;
  logic [4*N_DIGITOS-1:0] snap_dig;
  logic [N_DIGITOS-1:0]   snap_punto;
  logic                   tick;
  logic                   fin_scan;
  logic [3:0]             nibble;
  logic                   punto_sel;
  logic                   blank_sel;
  logic [N_DIGITOS-1:0]   one_hot;

  assign tick     = (prescaler == PRESC_MAX);
  assign fin_scan = habilitar && tick && (index == IDX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      index     <= '0;
    end else if (!habilitar) begin
      prescaler <= '0;
      index     <= '0;
    end else if (tick) begin
      prescaler <= '0;
      index     <= (index == IDX_MAX) ? '0 : index + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Snapshot is transparent while disabled and otherwise only reloads at scan end,
  // so a scan never mixes digits from two different input words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_dig   <= '0;
      snap_punto <= '0;
    end else if (!habilitar || fin_scan) begin
      snap_dig   <= digitos;
      snap_punto <= punto;
    end
  end

  always_comb begin
    nibble    = snap_dig[4*int'(index) +: 4];
    punto_sel = snap_punto[index];
    one_hot   = N_DIGITOS'(1) << index;
  end

`ifdef SUPRESION_CEROS_EN
  logic [N_DIGITOS-1:0] blank;
  logic                 zeros_acc;

  // Walk down from the most significant digit; a slot stays blank while all
  // nibbles at and above it are zero. Digit 0 is never blanked.
  always_comb begin
    blank     = '0;
    zeros_acc = 1'b1;
    for (int i = N_DIGITOS - 1; i > 0; i--) begin
      zeros_acc = zeros_acc && (snap_dig[4*i +: 4] == 4'h0);
      blank[i]  = zeros_acc;
    end
  end

  assign blank_sel = blank[index];
`else
  assign blank_sel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd         <= 4'h0;
      anodos      <= '1;
      dp          <= 1'b1;
      fin_barrido <= 1'b0;
    end else if (!habilitar) begin
      bcd         <= snap_dig[3:0];
      anodos      <= '1;
      dp          <= 1'b1;
      fin_barrido <= 1'b0;
    end else begin
      bcd         <= nibble;
      anodos      <= blank_sel ? '1 : ~one_hot;
      dp          <= blank_sel | ~punto_sel;
      fin_barrido <= fin_scan;
    end
  end

endmodule

// File: doc/controlador_displays.md
Name: controlador_displays

Overview:
Time-multiplexed scan controller for an N-digit common-anode 7-segment bank. Captures a packed BCD word and decimal-point mask, then cycles one digit at a time at a programmable refresh rate. It drives the 4-bit BCD nibble into the downstream BCD-to-7-segment decoder, plus the active-low anode and decimal-point lines. It sits directly upstream of that decoder, between the datapath that produces BCD digits and the board pins.

Parameters:
N_DIGITOS, 4, number of digits scanned; legal range 1..8.
DIV_REFRESCO, 50000, clock cycles each digit stays lit; legal minimum 2.
ANCHO_DIV, $clog2(DIV_REFRESCO), prescaler width; derived locally, not overridable.

Ports:
clk  input  1  system clock, single domain.
rst_n  input  1  asynchronous, active-low reset.
digitos  input  4*N_DIGITOS  packed BCD digits; digit 0 (rightmost) = bits [3:0].
punto  input  N_DIGITOS  decimal-point request per digit, active-high.
habilitar  input  1  scan enable; low blanks the whole bank.
bcd  output  4  current digit nibble to the 7-segment decoder.
anodos  output  N_DIGITOS  anode enables, active-low, at most one low at a time.
dp  output  1  decimal-point segment, active-low.
fin_barrido  output  1  one-cycle pulse when a full scan completes.

Behaviour:
- Reset (rst_n low, asynchronous): prescaler=0, index=0, snapshot registers=0, bcd=4'h0, anodos=all 1, dp=1, fin_barrido=0.
- Prescaler counts 0..DIV_REFRESCO-1 while habilitar=1.
  - tick = (prescaler==DIV_REFRESCO-1).
  - On tick the prescaler wraps to 0.
- Index advances on tick: 0,1,...,N_DIGITOS-1, then back to 0.
  - At the edge where index wraps N_DIGITOS-1 -> 0, the snapshot registers load digitos and punto.
  - fin_barrido=1 for exactly the cycle following that edge.
- Snapshot guarantees a tear-free scan: input changes mid-scan are visible only from the next digit-0 slot.
- Outputs are registered with 1-cycle latency from (index, snapshot).
  - bcd = snapshot nibble[index].
  - anodos = ~(1<<index).
  - dp = ~snapshot_punto[index].
- habilitar=0:
  - prescaler and index are forced to 0.
  - Snapshot loads digitos and punto every cycle (transparent).
  - Next cycle: anodos=all 1, dp=1, bcd=snapshot nibble 0, fin_barrido=0.
- habilitar 0->1: scan starts at digit 0 using the snapshot taken on the last disabled cycle; first tick occurs DIV_REFRESCO cycles later.
- N_DIGITOS=1: index is constant 0; every tick is a scan end, so fin_barrido pulses every DIV_REFRESCO cycles.
- bcd values 10..15 are passed through unchanged; glyph choice belongs to the decoder.
- Reset asserted mid-scan: outputs return to reset values immediately, without waiting for a clock edge; scanning restarts at digit 0 after release.

Optional Feature:
Macro SUPRESION_CEROS_EN (leading-zero blanking).
- Defined: digit i>0 is blanked when its snapshot nibble and every higher nibble are all 0.
  - Blanked slot: anodos=all 1 and dp=1 during that slot; timing and fin_barrido are unchanged.
  - Digit 0 is never blanked.
- Undefined: every digit is displayed; no blanking logic is synthesised.

Test Plan:
1. rst_n low with no clock running -> anodos=4'b1111, bcd=0, dp=1, fin_barrido=0 immediately.
2. N_DIGITOS=4, DIV_REFRESCO=4, digitos=16'h1234, punto=4'b0100, habilitar=1 -> each value held 4 cycles:
   - anodos 1110/1101/1011/0111;
   - bcd 4/3/2/1;
   - dp low only in the anodos=1011 slot;
   - fin_barrido pulses once every 16 cycles.
3. Change digitos to 16'h5678 during the digit-2 slot -> digits 2,3 still show 2,1; next scan shows 8,7,6,5.
4. Drop habilitar during digit 1 -> next cycle anodos=1111, dp=1; raise habilitar -> digit 0 lit for the full 4 cycles, then normal rotation.
5. Assert rst_n low during digit 3 between clock edges -> outputs take reset values asynchronously; after release, scan resumes at digit 0.
6. With SUPRESION_CEROS_EN defined:
   - digitos=16'h0050 -> digit-3 and digit-2 slots show anodos=1111; digit 1 shows bcd 5; digit 0 shows bcd 0.
   - digitos=16'h0000 -> only digit 0 is lit.
